bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
- Two-digit BCD (00-99) loadable down-counter/timer with a run/hold/done control FSM.
- Complementary to the team's two-digit BCD up-counter: counts toward 00, raises a borrow for cascading, and signals terminal count.
- Sits beside the up-counter in the timing/display datapath and feeds seven-segment decoders via DOUT2/DOUT1.

Parameters:
- AUTO_RELOAD, 0, 1 = after reaching 00, the next tick reloads the stored start value and the timer keeps running; 0 = stop in DONE.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  count tick enable; one decrement per CLK edge with EN=1 in RUN.
- LOAD  in  1  load DIN2/DIN1 as the new start value.
- DIN2  in  4  tens digit to load (BCD).
- DIN1  in  4  units digit to load (BCD).
- START  in  1  start or resume counting.
- STOP  in  1  pause counting.
- DOUT2  out  4  current tens digit.
- DOUT1  out  4  current units digit.
- BOUT  out  1  combinational borrow: 1 when DOUT=00, state RUN and EN=1.
- TC  out  1  registered one-cycle pulse on the 01->00 transition.
- BUSY  out  1  1 in RUN or HOLD.
- ERR  out  1  registered one-cycle pulse when LOAD carries a non-BCD digit.

Behaviour:
- Reset (RST=0, async): DOUT2=DOUT1=0, reload register=00, state IDLE, TC=0, ERR=0, BUSY=0. Reset mid-count aborts immediately. No pending pulse survives reset.
- States: IDLE, RUN, HOLD, DONE.
- Input priority per edge: LOAD > STOP > START > EN.
- LOAD, any state:
  - Both digits <=9: DOUT and reload register take DIN at that edge, state goes to IDLE, and any tick that cycle is ignored.
  - Either digit >9: ERR=1 next cycle; value, reload register and state are unchanged.
- IDLE:
  - START with value!=00 goes to RUN on that edge; the first decrement happens on a later EN edge.
  - START with value=00 is ignored.
- RUN, EN=1:
  - Units digit >0: units digit decrements.
  - Units digit =0 and value !=00: units digit becomes 9 and tens digit decrements.
  - Value=01: becomes 00, TC=1 for exactly one cycle. With AUTO_RELOAD=0 the state goes to DONE on the same edge; with AUTO_RELOAD=1 it stays in RUN.
  - Value=00 (AUTO_RELOAD=1 only): value takes the reload register on this edge, so the period is reload+1 ticks.
- RUN, EN=0: value holds.
- STOP: RUN goes to HOLD and the value freezes. STOP in IDLE, HOLD or DONE is a no-op.
- HOLD: START returns to RUN with no decrement on that edge.
- DONE:
  - Value holds 00 and BUSY=0.
  - START copies the reload register into DOUT and goes to RUN, unless reload=00, in which case it is ignored.
- Simultaneous inputs:
  - START+STOP: STOP wins.
  - START+EN: state transition only, no decrement.
  - LOAD+anything: LOAD wins.
- Combinational outputs: BOUT is combinational (for cascading into a higher-order stage). All other outputs are registered.
- Range: DOUT digits are never >9 in any state.

Decomposition:
- Shared package bcd_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3).
  - BCD_MAX=4'd9.
  - Function is_bcd(4-bit).
- Sub-module bcd_digit_dn: one digit register with load, decrement-enable, borrow-in/borrow-out and 9-on-underflow. It is instantiated twice (units, tens), with the units borrow driving the tens decrement. The FSM and the TC/ERR registers live in the top level.

Test Plan:
- Reset during RUN at value 57 -> DOUT=00, BUSY=0, TC=0 asynchronously, before the next edge.
- LOAD 23, START, 3 EN ticks -> 22, 21, 20; 4th tick -> 19 (units wraps to 9, tens decrements).
- LOAD 02, START, EN continuous, AUTO_RELOAD=0 -> 01, then 00 with TC high for one cycle; state DONE, BUSY=0; further EN leaves 00; START -> DOUT=02, RUN.
- AUTO_RELOAD=1, LOAD 02, START, EN continuous -> sequence 01, 00, 02, 01, 00; TC pulses every 3 ticks; BOUT high during the 00 ticks.
- LOAD DIN2=4'hA, DIN1=3 -> ERR one-cycle pulse; DOUT and state unchanged. LOAD 99 with EN=1 in RUN -> DOUT=99, state IDLE, no decrement.
- In RUN at 45: STOP+START same cycle -> HOLD, DOUT stays 45 under EN; START+EN -> RUN, still 45; next EN -> 44.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the BCD down-timer
// Purpose: control FSM state encoding, BCD digit limit and digit validity check.
// Ports: none (package).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// rtl/bcd_down_timer_if.sv - control/data bundle of the BCD down-timer
// Purpose: groups the command inputs and digit/status outputs of bcd_down_timer.
// Signals: EN, LOAD, DIN2, DIN1, START, STOP (to timer);
//          DOUT2, DOUT1, BOUT, TC, BUSY, ERR (from timer).
// Modports: master = controller side, slave = timer side.
interface bcd_down_timer_if;

  logic       EN;
  logic       LOAD;
  logic [3:0] DIN2;
  logic [3:0] DIN1;
  logic       START;
  logic       STOP;
  logic [3:0] DOUT2;
  logic [3:0] DOUT1;
  logic       BOUT;
  logic       TC;
  logic       BUSY;
  logic       ERR;

  modport master (
    output EN, LOAD, DIN2, DIN1, START, STOP,
    input  DOUT2, DOUT1, BOUT, TC, BUSY, ERR
  );

  modport slave (
    input  EN, LOAD, DIN2, DIN1, START, STOP,
    output DOUT2, DOUT1, BOUT, TC, BUSY, ERR
  );

endinterface

// File: rtl/bcd_digit_dn.sv
// rtl/bcd_digit_dn.sv - one BCD digit register with load and decrement
// Purpose: holds a 0-9 digit; decrements when dec and bin are both set,
//          wrapping 0 -> 9 and signalling the wrap on bout.
// Ports: CLK, RST (async active-low), load/din (parallel load),
//        dec (decrement enable), bin (borrow in), bout (borrow out), q (digit).
module bcd_digit_dn
  import bcd_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  input  logic       bin,
  output logic       bout,
  output logic [3:0] q
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= 4'd0;
    end else if (load) begin
      q <= din;
    end else if (dec && bin) begin
      q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

  // A borrow requested of a zero digit propagates to the next digit up.
  assign bout = bin && (q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - two-digit BCD loadable down-counter with run/hold/done FSM
// Purpose: counts 99..00 on EN ticks while running, pulses TC on 01->00,
//          optionally reloads the start value, and flags non-BCD loads on ERR.
// Ports: CLK (rising edge), RST (async active-low),
//        bus (slave): EN, LOAD, DIN2, DIN1, START, STOP in;
//                     DOUT2, DOUT1, BOUT (combinational), TC, BUSY, ERR out.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  bcd_down_timer_if.slave      bus
);

  state_t     state, state_nx;
  logic [7:0] reload_q;
  logic [3:0] q1, q2;
  logic       units_bout, tens_bout;
  logic       dig_load, dig_dec, src_din, tc_nx;
  logic       load_ok, load_bad, is_zero, is_one;
  logic [3:0] ld1, ld2;
  logic       tc_q, err_q;

  assign load_ok  = bus.LOAD && is_bcd(bus.DIN2) && is_bcd(bus.DIN1);
  assign load_bad = bus.LOAD && !load_ok;
  assign is_zero  = (q2 == 4'd0) && (q1 == 4'd0);
  assign is_one   = (q2 == 4'd0) && (q1 == 4'd1);

  always_comb begin
    state_nx = state;
    dig_load = 1'b0;
    dig_dec  = 1'b0;
    src_din  = 1'b0;
    tc_nx    = 1'b0;
    if (bus.LOAD) begin
      // A rejected load leaves everything alone but still blocks lower-priority inputs.
      if (load_ok) begin
        dig_load = 1'b1;
        src_din  = 1'b1;
        state_nx = IDLE;
      end
    end else if (bus.STOP) begin
      if (state == RUN) state_nx = HOLD;
    end else if (bus.START) begin
      unique case (state)
        IDLE: if (!is_zero) state_nx = RUN;
        HOLD: state_nx = RUN;
        DONE: begin
          if (reload_q != 8'h00) begin
            dig_load = 1'b1;
            state_nx = RUN;
          end
        end
        default: ;
      endcase
    end else if (bus.EN && (state == RUN)) begin
      if (is_zero) begin
        if (AUTO_RELOAD) dig_load = 1'b1;
      end else begin
        dig_dec = 1'b1;
        if (is_one) begin
          tc_nx = 1'b1;
          if (!AUTO_RELOAD) state_nx = DONE;
        end
      end
    end
  end

  assign ld2 = src_din ? bus.DIN2 : reload_q[7:4];
  assign ld1 = src_din ? bus.DIN1 : reload_q[3:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      reload_q <= 8'h00;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      tc_q  <= tc_nx;
      err_q <= load_bad;
      if (load_ok) reload_q <= {bus.DIN2, bus.DIN1};
    end
  end

  bcd_digit_dn u_units (
    .CLK  (CLK),
    .RST  (RST),
    .load (dig_load),
    .din  (ld1),
    .dec  (dig_dec),
    .bin  (1'b1),
    .bout (units_bout),
    .q    (q1)
  );

  // Tens only moves when the units digit wraps from 0 to 9.
  bcd_digit_dn u_tens (
    .CLK  (CLK),
    .RST  (RST),
    .load (dig_load),
    .din  (ld2),
    .dec  (dig_dec),
    .bin  (units_bout),
    .bout (tens_bout),
    .q    (q2)
  );

  logic unused_tens_bout;
  assign unused_tens_bout = tens_bout;

  assign bus.DOUT2 = q2;
  assign bus.DOUT1 = q1;
  assign bus.TC    = tc_q;
  assign bus.ERR   = err_q;
  assign bus.BUSY  = (state == RUN) || (state == HOLD);
  assign bus.BOUT  = is_zero && (state == RUN) && bus.EN;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - self-checking bench for bcd_down_timer (both reload modes)
module tb_bcd_down_timer;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  bcd_down_timer_if if0 ();
  bcd_down_timer_if if1 ();

  bcd_down_timer #(.AUTO_RELOAD(1'b0)) dut0 (.CLK(CLK), .RST(RST), .bus(if0.slave));
  bcd_down_timer #(.AUTO_RELOAD(1'b1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

  logic       sel = 1'b0;
  logic       en = 0, load = 0, start = 0, stop = 0;
  logic [3:0] din2 = 0, din1 = 0;

  assign if0.EN    = sel ? 1'b0 : en;
  assign if0.LOAD  = sel ? 1'b0 : load;
  assign if0.START = sel ? 1'b0 : start;
  assign if0.STOP  = sel ? 1'b0 : stop;
  assign if0.DIN2  = din2;
  assign if0.DIN1  = din1;
  assign if1.EN    = sel ? en : 1'b0;
  assign if1.LOAD  = sel ? load : 1'b0;
  assign if1.START = sel ? start : 1'b0;
  assign if1.STOP  = sel ? stop : 1'b0;
  assign if1.DIN2  = din2;
  assign if1.DIN1  = din1;

  logic [7:0] o_dout;
  logic       o_tc, o_busy, o_err, o_bout;
  always_comb begin
    o_dout = sel ? {if1.DOUT2, if1.DOUT1} : {if0.DOUT2, if0.DOUT1};
    o_tc   = sel ? if1.TC   : if0.TC;
    o_busy = sel ? if1.BUSY : if0.BUSY;
    o_err  = sel ? if1.ERR  : if0.ERR;
    o_bout = sel ? if1.BOUT : if0.BOUT;
  end

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       tc;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // One clock: apply inputs, check BOUT before the edge, push expected post-edge
  // outputs, then pop and compare after the edge.
  task automatic tick(input string tag, input logic e, input logic l,
                      input logic [3:0] d2, input logic [3:0] d1,
                      input logic s, input logic p,
                      input logic [7:0] xd, input logic xtc, input logic xbusy,
                      input logic xerr, input logic xbout);
    exp_t x, got;
    en = e; load = l; din2 = d2; din1 = d1; start = s; stop = p;
    #1;
    checks++;
    if (o_bout !== xbout) begin
      errors++;
      $display("FAIL %s bout: got %b expected %b", tag, o_bout, xbout);
    end
    x.tag = tag; x.dout = xd; x.tc = xtc; x.busy = xbusy; x.err = xerr;
    exp_q.push_back(x);
    @(posedge CLK);
    #1;
    got = exp_q.pop_front();
    checks++;
    if ({o_dout, o_tc, o_busy, o_err} !== {got.dout, got.tc, got.busy, got.err}) begin
      errors++;
      $display("FAIL %s: got dout=%h tc=%b busy=%b err=%b expected dout=%h tc=%b busy=%b err=%b",
               got.tag, o_dout, o_tc, o_busy, o_err, got.dout, got.tc, got.busy, got.err);
    end
    en = 0; load = 0; start = 0; stop = 0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    #2;
    checks++;
    if ({o_dout, o_tc, o_busy, o_err} !== 11'h0) begin
      errors++;
      $display("FAIL reset_init: got dout=%h tc=%b busy=%b err=%b expected 00 0 0 0",
               o_dout, o_tc, o_busy, o_err);
    end
    @(negedge CLK);
    RST = 1'b1;
    tick("rst_load57", 0, 1, 4'd5, 4'd7, 0, 0, 8'h57, 0, 0, 0, 0);
    tick("rst_start",  0, 0, 4'd0, 4'd0, 1, 0, 8'h57, 0, 1, 0, 0);
    tick("rst_en",     1, 0, 4'd0, 4'd0, 0, 0, 8'h56, 0, 1, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({o_dout, o_tc, o_busy} !== 10'h0) begin
      errors++;
      $display("FAIL reset_async: got dout=%h tc=%b busy=%b expected 00 0 0", o_dout, o_tc, o_busy);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_count();
    sel = 1'b0;
    tick("cnt_load23", 0, 1, 4'd2, 4'd3, 0, 0, 8'h23, 0, 0, 0, 0);
    tick("cnt_start",  0, 0, 4'd0, 4'd0, 1, 0, 8'h23, 0, 1, 0, 0);
    tick("cnt_22",     1, 0, 4'd0, 4'd0, 0, 0, 8'h22, 0, 1, 0, 0);
    tick("cnt_21",     1, 0, 4'd0, 4'd0, 0, 0, 8'h21, 0, 1, 0, 0);
    tick("cnt_20",     1, 0, 4'd0, 4'd0, 0, 0, 8'h20, 0, 1, 0, 0);
    tick("cnt_19",     1, 0, 4'd0, 4'd0, 0, 0, 8'h19, 0, 1, 0, 0);
    tick("cnt_noen",   0, 0, 4'd0, 4'd0, 0, 0, 8'h19, 0, 1, 0, 0);
  endtask

  task automatic test_done();
    sel = 1'b0;
    tick("done_load02", 0, 1, 4'd0, 4'd2, 0, 0, 8'h02, 0, 0, 0, 0);
    tick("done_start",  0, 0, 4'd0, 4'd0, 1, 0, 8'h02, 0, 1, 0, 0);
    tick("done_01",     1, 0, 4'd0, 4'd0, 0, 0, 8'h01, 0, 1, 0, 0);
    tick("done_00",     1, 0, 4'd0, 4'd0, 0, 0, 8'h00, 1, 0, 0, 0);
    tick("done_hold0",  1, 0, 4'd0, 4'd0, 0, 0, 8'h00, 0, 0, 0, 0);
    tick("done_hold1",  1, 0, 4'd0, 4'd0, 0, 0, 8'h00, 0, 0, 0, 0);
    tick("done_restart",0, 0, 4'd0, 4'd0, 1, 0, 8'h02, 0, 1, 0, 0);
    tick("done_again",  1, 0, 4'd0, 4'd0, 0, 0, 8'h01, 0, 1, 0, 0);
  endtask

  task automatic test_reload();
    sel = 1'b1;
    tick("ar_load02", 0, 1, 4'd0, 4'd2, 0, 0, 8'h02, 0, 0, 0, 0);
    tick("ar_start",  0, 0, 4'd0, 4'd0, 1, 0, 8'h02, 0, 1, 0, 0);
    for (int p = 0; p < 2; p++) begin
      tick("ar_01",   1, 0, 4'd0, 4'd0, 0, 0, 8'h01, 0, 1, 0, 0);
      tick("ar_00",   1, 0, 4'd0, 4'd0, 0, 0, 8'h00, 1, 1, 0, 0);
      tick("ar_rel",  1, 0, 4'd0, 4'd0, 0, 0, 8'h02, 0, 1, 0, 1);
    end
    sel = 1'b0;
  endtask

  task automatic test_err();
    sel = 1'b0;
    tick("err_load23", 0, 1, 4'd2, 4'd3, 0, 0, 8'h23, 0, 0, 0, 0);
    tick("err_start",  0, 0, 4'd0, 4'd0, 1, 0, 8'h23, 0, 1, 0, 0);
    tick("err_badA3",  0, 1, 4'hA, 4'd3, 0, 0, 8'h23, 0, 1, 1, 0);
    tick("err_clear",  1, 0, 4'd0, 4'd0, 0, 0, 8'h22, 0, 1, 0, 0);
    tick("err_bad2F",  1, 1, 4'd2, 4'hF, 0, 0, 8'h22, 0, 1, 1, 0);
    tick("err_load99", 1, 1, 4'd9, 4'd9, 0, 0, 8'h99, 0, 0, 0, 0);
    tick("err_idle",   1, 0, 4'd0, 4'd0, 0, 0, 8'h99, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    tick("hold_load45", 0, 1, 4'd4, 4'd5, 0, 0, 8'h45, 0, 0, 0, 0);
    tick("hold_start",  0, 0, 4'd0, 4'd0, 1, 0, 8'h45, 0, 1, 0, 0);
    tick("hold_stopst", 0, 0, 4'd0, 4'd0, 1, 1, 8'h45, 0, 1, 0, 0);
    tick("hold_en",     1, 0, 4'd0, 4'd0, 0, 0, 8'h45, 0, 1, 0, 0);
    tick("hold_st_en",  1, 0, 4'd0, 4'd0, 1, 0, 8'h45, 0, 1, 0, 0);
    tick("hold_44",     1, 0, 4'd0, 4'd0, 0, 0, 8'h44, 0, 1, 0, 0);
    tick("hold_stop",   0, 0, 4'd0, 4'd0, 0, 1, 8'h44, 0, 1, 0, 0);
    tick("hold_idle0",  0, 1, 4'd0, 4'd0, 0, 0, 8'h00, 0, 0, 0, 0);
    tick("hold_st00",   0, 0, 4'd0, 4'd0, 1, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_count();
    test_done();
    test_reload();
    test_err();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
